// File: rtl/intpol2_pkg.sv
// Shared definitions for the quadratic I/Q interpolator datapath.
// Contents:
//   DEFAULT_DATAPATH_WIDTH - default width of each signed I and Q sample
//   iq_pair                - packed {I, Q} sample pair at the default width
//   level_flags_t          - status flags decoded from a buffer occupancy
//   level_to_flags()       - occupancy -> {valid, afull, full} decode
package intpol2_pkg;

    localparam int unsigned DEFAULT_DATAPATH_WIDTH = 12;

    typedef struct packed {
        logic signed [DEFAULT_DATAPATH_WIDTH-1:0] I;
        logic signed [DEFAULT_DATAPATH_WIDTH-1:0] Q;
    } iq_pair;

    typedef struct packed {
        logic valid;
        logic afull;
        logic full;
    } level_flags_t;

    // Flags are pure decodes of the registered occupancy, so they carry no
    // extra pipeline delay relative to the level itself.
    function automatic level_flags_t level_to_flags(input int unsigned level,
                                                    input int unsigned depth,
                                                    input int unsigned margin);
        level_flags_t f;
        f.valid = (level != 0);
        f.full  = (level == depth);
        f.afull = (level >= depth - margin);
        return f;
    endfunction

endpackage

// File: rtl/intpol2_sync_ram.sv
// Single-clock dual-port storage array: registered write, combinational read.
// Contents are not reset.
// Ports:
//   clk_i   - clock, writes on posedge
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (combinational from raddr_i)
module intpol2_sync_ram #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    import intpol2_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/intpol2_iq_out_fifo.sv
// First-word-fall-through I/Q output buffer behind the interpolator core.
// Captures an {I, Q} pair on every accepted wr_en, returns almost-full
// back-pressure to the core, and presents the head pair on a valid/ready
// stream.
// Ports:
//   clk, rst (sync, active-high), flush (sync clear, sticky flags kept)
//   wr_en, wr_I, wr_Q        - write side from the core
//   afull, full              - back-pressure / occupancy flags
//   m_valid, m_ready, m_I, m_Q - output stream (FWFT)
//   level                    - occupancy 0..DEPTH
//   overflow, underflow      - sticky error flags, cleared only by rst
module intpol2_iq_out_fifo #(
    parameter int unsigned DATAPATH_WIDTH = intpol2_pkg::DEFAULT_DATAPATH_WIDTH,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned AFULL_MARGIN   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [DATAPATH_WIDTH-1:0] wr_I,
    input  logic [DATAPATH_WIDTH-1:0] wr_Q,
    output logic                      afull,
    output logic                      full,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATAPATH_WIDTH-1:0] m_I,
    output logic [DATAPATH_WIDTH-1:0] m_Q,
    output logic [ADDR_WIDTH:0]       level,
    output logic                      overflow,
    output logic                      underflow
);
    import intpol2_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PAIR_W = 2 * DATAPATH_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    level_flags_t          flags;
    logic                  push, pop, ram_we;
    logic [PAIR_W-1:0]     head;

    assign flags = level_to_flags(32'(level_q), DEPTH, AFULL_MARGIN);

    // full is taken from the registered level, so a pop in the same cycle
    // does not make room for a write arriving while full.
    assign push   = wr_en & ~flags.full;
    assign pop    = flags.valid & m_ready;
    assign ram_we = push & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + (ADDR_WIDTH+1)'(1);
            else if (pop && !push) level_d = level_q - (ADDR_WIDTH+1)'(1);
            if (wr_en && flags.full)     overflow_d  = 1'b1;
            if (m_ready && !flags.valid) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    intpol2_sync_ram #(
        .WIDTH      (PAIR_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({wr_I, wr_Q}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign m_I       = head[PAIR_W-1:DATAPATH_WIDTH];
    assign m_Q       = head[DATAPATH_WIDTH-1:0];
    assign m_valid   = flags.valid;
    assign full      = flags.full;
    assign afull     = flags.afull;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_intpol2_iq_out_fifo.sv
module tb_intpol2_iq_out_fifo;
    import intpol2_pkg::*;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst, flush, wr_en, m_ready;
    logic [W-1:0] wr_I, wr_Q;
    logic         afull, full, m_valid, overflow, underflow;
    logic [W-1:0] m_I, m_Q;
    logic [4:0]   level;

    int total = 0;
    int bad   = 0;
    int mlevel = 0;
    iq_pair exp_q[$];
    iq_pair hold;

    always #5 clk = ~clk;

    intpol2_iq_out_fifo #(
        .DATAPATH_WIDTH (W),
        .ADDR_WIDTH     (4),
        .AFULL_MARGIN   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_I      (wr_I),
        .wr_Q      (wr_Q),
        .afull     (afull),
        .full      (full),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_I       (m_I),
        .m_Q       (m_Q),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted output pair is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && !flush && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got I=%0d Q=%0d expected none",
                         $signed(m_I), $signed(m_Q));
            end else begin
                hold = exp_q.pop_front();
                chk("pop_I", int'($signed(m_I)), int'(hold.I));
                chk("pop_Q", int'($signed(m_Q)), int'(hold.Q));
            end
        end
    end

    // One cycle of stimulus; the bench's own occupancy model decides which
    // writes are expected to be accepted.
    task automatic step(input logic wr, input int di, input logic rdy);
        iq_pair p;
        @(posedge clk);
        #1;
        wr_en   = wr;
        wr_I    = W'(di);
        wr_Q    = W'(-di);
        m_ready = rdy;
        if (wr && mlevel != 16) begin
            p.I = W'(di);
            p.Q = W'(-di);
            exp_q.push_back(p);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        if (wr && mlevel != 16 && !(rdy && mlevel != 0)) mlevel++;
        else if (!(wr && mlevel != 16) && rdy && mlevel != 0) mlevel--;
        wr_en   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mlevel = 0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; m_ready = 1'b0;
        wr_I = '0; wr_Q = '0;

        // 1. reset then idle
        do_reset();
        @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_afull", int'(afull), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);

        // 2. fill with no reader
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, k, 1'b0);
            if (k == 13) chk("afull_at13", int'(afull), 0);
            if (k == 14) chk("afull_at14", int'(afull), 1);
            if (k == 15) chk("full_at15", int'(full), 0);
        end
        chk("fill_level", int'(level), 16);
        chk("fill_full", int'(full), 1);
        chk("fill_overflow", int'(overflow), 0);
        step(1'b1, 17, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_level", int'(level), 16);

        // 3. drain
        for (int k = 1; k <= 16; k++) step(1'b0, 0, 1'b1);
        chk("drain_valid", int'(m_valid), 0);
        chk("drain_level", int'(level), 0);
        chk("drain_underflow", int'(underflow), 0);
        step(1'b0, 0, 1'b1);
        chk("underflow_set", int'(underflow), 1);

        // 4. simultaneous push/pop at level 5, then at full
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 100 + k, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 200 + k, 1'b1);
            chk("pp_level", int'(level), 5);
        end
        for (int k = 0; k < 11; k++) step(1'b1, 300 + k, 1'b0);
        chk("pp_full", int'(full), 1);
        chk("pp_ovf_before", int'(overflow), 0);
        step(1'b1, 999, 1'b1);
        chk("pp_full_level", int'(level), 15);
        chk("pp_full_ovf", int'(overflow), 1);
        for (int k = 0; k < 15; k++) step(1'b0, 0, 1'b1);
        chk("pp_drained", exp_q.size(), 0);

        // 5. back-pressure hold
        for (int k = 0; k < 3; k++) step(1'b1, -50 - k, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 400 + k, 1'b0);
            hold = exp_q[0];
            chk("hold_I", int'($signed(m_I)), int'(hold.I));
            chk("hold_Q", int'($signed(m_Q)), int'(hold.Q));
        end
        chk("hold_level", int'(level), 7);

        // 6. flush at level 9 with a write, refill, mid-stream reset
        for (int k = 0; k < 2; k++) step(1'b1, 500 + k, 1'b0);
        chk("pre_flush_level", int'(level), 9);
        @(posedge clk); #1;
        flush = 1'b1; wr_en = 1'b1; wr_I = W'(777); wr_Q = W'(-777);
        @(posedge clk); #1;
        flush = 1'b0; wr_en = 1'b0;
        mlevel = 0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_level", int'(level), 0);
        chk("flush_valid", int'(m_valid), 0);
        chk("flush_ovf_kept", int'(overflow), 1);
        for (int k = 0; k < 7; k++) step(1'b1, 600 + k, 1'b0);
        chk("refill_level", int'(level), 7);
        hold = exp_q[0];
        chk("refill_head_I", int'($signed(m_I)), int'(hold.I));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mlevel = 0;
        exp_q.delete();
        @(negedge clk);
        chk("mrst_level", int'(level), 0);
        chk("mrst_valid", int'(m_valid), 0);
        chk("mrst_full", int'(full), 0);
        chk("mrst_afull", int'(afull), 0);
        chk("mrst_overflow", int'(overflow), 0);
        chk("mrst_underflow", int'(underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/intpol2_iq_out_fifo.md
Name: intpol2_iq_out_fifo

Overview:
Synchronous I/Q output buffer directly downstream of the quadratic I/Q interpolator core.
- Captures each interpolated I/Q pair when the core pulses its FIFO write enable.
- Returns the almost-full back-pressure flag the core uses to stall.
- Presents the buffered pairs to the next stage on a valid/ready stream, first-word-fall-through.

Parameters:
- DATAPATH_WIDTH, 12, width of each I and Q sample (signed, two's complement).
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries (16).
- AFULL_MARGIN, 2, afull asserts when level >= DEPTH - AFULL_MARGIN; legal range 1..DEPTH-1.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of contents and pointers; sticky flags kept.
- wr_en  in  1  write strobe from the core (Write_Enable_fifo).
- wr_I  in  DATAPATH_WIDTH  I sample from the core.
- wr_Q  in  DATAPATH_WIDTH  Q sample from the core.
- afull  out  1  almost full; feeds the core's Afull_i.
- full  out  1  level == DEPTH.
- m_valid  out  1  head entry available.
- m_ready  in  1  downstream accepts the head entry.
- m_I  out  DATAPATH_WIDTH  head I sample.
- m_Q  out  DATAPATH_WIDTH  head Q sample.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped while full.
- underflow  out  1  sticky: m_ready was asserted while m_valid was low (informational only).

Behaviour:
- Reset values (rst=1 at a posedge): wr_ptr=0, rd_ptr=0, level=0, m_valid=0, full=0, afull=0, overflow=0, underflow=0.
- Storage array contents are not reset. m_I/m_Q are don't-care while m_valid=0; the bench must not check them.
- Reset has priority over flush. Reset mid-stream discards everything in the same cycle.
- Write accept: push = wr_en & ~full.
  - On push, mem[wr_ptr] <= {wr_I, wr_Q}; wr_ptr increments and wraps modulo DEPTH.
- Read accept: pop = m_valid & m_ready. On pop, rd_ptr increments and wraps modulo DEPTH.
- Level update: +1 on push only, -1 on pop only, unchanged when both occur.
- Full with simultaneous pop and wr_en: the write is dropped. full is evaluated on the registered level before the pop. overflow is set.
- Empty with wr_en: m_valid cannot be high, so no pop occurs.
- Flags are combinational decodes of the registered level, so there are no extra pipeline stages:
  - m_valid = (level != 0)
  - full = (level == DEPTH)
  - afull = (level >= DEPTH - AFULL_MARGIN)
- Head output: m_I/m_Q = mem[rd_ptr], read combinationally (FWFT).
- Latency: a pair written at edge N gives m_valid=1 with that data after edge N (visible in cycle N+1). There is no fall-through in the same cycle.
- Stream rule: m_I/m_Q stay stable while m_valid=1 and m_ready=0.
- Flush: level=0 and pointers=0 on the next edge. A push or pop in the same cycle is ignored. overflow and underflow are unchanged.
- Sticky flags: overflow and underflow are cleared only by rst.
- Ordering: strict FIFO. The I/Q pairing of each write is never split.

Decomposition:
- Shared package intpol2_pkg holds:
  - default DATAPATH_WIDTH
  - the iq_pair typedef {I, Q} (2*DATAPATH_WIDTH)
  - the level-to-flag helper function used by the core and this block
- One natural sub-module: intpol2_sync_ram, a single-clock dual-port array with registered write and combinational read. Reused later for the input-side buffer.
- Pointer/level/flag logic lives in the top module.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, release -> level=0, m_valid=0, afull=0, full=0, overflow=0.
2. Fill with m_ready=0, 16 writes I=k, Q=-k (k=1..16) -> afull rises after the 14th write (level=14); full after the 16th. A 17th write sets overflow=1 and level stays 16.
3. Drain with m_ready=1 -> 16 consecutive pops; pair k has m_I=k, m_Q=-k; m_valid falls after the 16th pop. Pointers wrap to 0.
4. Simultaneous push/pop at level=5 for 20 cycles with increasing data -> level stays 5 and output order is preserved. Then push/pop at full: the write is dropped, level goes to 15, overflow=1.
5. Back-pressure hold: m_valid=1, m_ready=0 for 4 cycles while writes continue -> m_I/m_Q unchanged across all 4 cycles.
6. Flush and mid-stream reset: at level=9, flush=1 together with wr_en=1 -> level=0 next cycle and overflow is kept. Refill to 7, assert rst -> all outputs back to reset values next cycle.
